// File: rtl/mux16_rr_sched.sv
// mux16_rr_sched: round-robin scheduler sharing one 16:1 bit mux among 16 requesters
module mux16_bit (
  input  logic [15:0] d_i,
  input  logic [3:0]  s_i,
  output logic        y_o
);
  assign y_o = d_i[s_i];
endmodule

module mux16_rr_sched #(
  parameter int NREQ  = 16,
  parameter int SELW  = 4,
  parameter int BURST = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [NREQ-1:0] in_data,
  input  logic            ready,
  output logic [SELW-1:0] sel,
  output logic [NREQ-1:0] gnt,
  output logic            valid,
  output logic            dout,
  output logic [NREQ-1:0] ack
);
  typedef enum logic {ARB, SERVE} state_t;
  localparam logic [SELW-1:0] BURST_W = SELW'(BURST);
  state_t state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d, ptr_q, ptr_d, cnt_q, cnt_d, off, winner;
  logic [NREQ-1:0] elig, rot;
  logic burst_c;
  // find first eligible requester at or after ptr by rotating the vector down
  always_comb begin
    elig = req & mask;
    rot = NREQ'({elig, elig} >> ptr_q);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) if (rot[i]) off = SELW'(i);
    burst_c = (cnt_q != '0) && (cnt_q < BURST_W) && elig[sel_q];
    winner = burst_c ? sel_q : ptr_q + off;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
      sel_q <= '0;
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  // next state: grant in ARB, wait for consumer acceptance in SERVE
  always_comb begin
    state_d = state_q;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (state_q == ARB) begin
      if (elig != '0) begin
        state_d = SERVE;
        sel_d = winner;
        cnt_d = burst_c ? cnt_q : '0;
      end
    end else if (ready) begin
      state_d = ARB;
      cnt_d = cnt_q + 1'b1;
      ptr_d = sel_q + 1'b1;
    end
  end
  // outputs: grant and ack only while serving
  always_comb begin
    valid = state_q == SERVE;
    sel = sel_q;
    gnt = valid ? NREQ'(1) << sel_q : '0;
    ack = gnt & {NREQ{valid & ready}};
  end
  mux16_bit u_mux (.d_i(in_data), .s_i(sel_q), .y_o(dout));
endmodule

// File: tb/tb_mux16_rr_sched.sv
// tb_mux16_rr_sched: scoreboard bench for the round-robin mux scheduler
module tb_mux16_rr_sched;
  logic clk = 0, rst_n = 0, ready = 1;
  logic [15:0] req = 0, mask = 16'hFFFF, in_data = 0;
  logic [3:0] sel1, sel3;
  logic [15:0] gnt1, gnt3, ack1, ack3;
  logic valid1, valid3, dout1, dout3;
  logic [3:0] q[$];
  logic [3:0] exp_sel;
  int n_cmp = 0, n_bad = 0;

  mux16_rr_sched #(.BURST(1)) u1 (.clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .in_data(in_data),
    .ready(ready), .sel(sel1), .gnt(gnt1), .valid(valid1), .dout(dout1), .ack(ack1));
  mux16_rr_sched #(.BURST(3)) u3 (.clk(clk), .rst_n(rst_n), .req(req), .mask(mask), .in_data(in_data),
    .ready(ready), .sel(sel3), .gnt(gnt3), .valid(valid3), .dout(dout3), .ack(ack3));

  always #5 clk = ~clk;

  task automatic do_reset();
    rst_n = 0; req = 0; mask = 16'hFFFF; ready = 1; in_data = 0; q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    n_cmp++;
    if ({valid1, gnt1, ack1, sel1} !== 37'd0 || {valid3, gnt3, ack3, sel3} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset: u1 v=%b g=%h a=%h s=%0d u3 v=%b g=%h a=%h s=%0d, want all 0",
               valid1, gnt1, ack1, sel1, valid3, gnt3, ack3, sel3);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 16'h0001;
    q.push_back(0); q.push_back(0); q.push_back(0);
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      @(negedge clk);
      n_cmp++;
      if (valid1 !== (c % 2 == 0)) begin
        n_bad++;
        $display("FAIL single_valid c=%0d: got %b want %b", c, valid1, c % 2 == 0);
      end
      if (valid1 && ready) begin
        exp_sel = q.pop_front();
        n_cmp++;
        if (sel1 !== exp_sel || ack1 !== (16'd1 << exp_sel) || dout1 !== in_data[exp_sel]) begin
          n_bad++;
          $display("FAIL single: sel=%0d ack=%h dout=%b want sel=%0d ack=%h dout=%b",
                   sel1, ack1, dout1, exp_sel, 16'd1 << exp_sel, in_data[exp_sel]);
        end
      end
      in_data = 16'($urandom);
    end
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL single_timeout: %0d left want 0", q.size()); end
    req = 0;
  endtask

  task automatic test_rotation();
    do_reset();
    req = 16'hFFFF;
    for (int i = 0; i < 18; i++) q.push_back(4'(i));
    for (int c = 0; c < 60 && q.size() > 0; c++) begin
      @(negedge clk);
      if (valid1 && ready) begin
        exp_sel = q.pop_front();
        n_cmp++;
        if (sel1 !== exp_sel || ack1 !== (16'd1 << exp_sel) || gnt1 !== (16'd1 << exp_sel) || dout1 !== in_data[exp_sel]) begin
          n_bad++;
          $display("FAIL rotation: sel=%0d ack=%h dout=%b want sel=%0d ack=%h dout=%b",
                   sel1, ack1, dout1, exp_sel, 16'd1 << exp_sel, in_data[exp_sel]);
        end
      end else if (ack1 !== 16'd0) begin
        n_cmp++; n_bad++;
        $display("FAIL rotation_ack: got %h want 0", ack1);
      end
      in_data = 16'($urandom);
    end
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL rotation_timeout: %0d left want 0", q.size()); end
    req = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    req = 16'h4000;
    q.push_back(14);
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 20 && q.size() > 0; c++) begin
        @(negedge clk);
        if (valid1 && ready) begin
          exp_sel = q.pop_front();
          n_cmp++;
          if (sel1 !== exp_sel || ack1 !== (16'd1 << exp_sel) || dout1 !== in_data[exp_sel]) begin
            n_bad++;
            $display("FAIL wrap: sel=%0d ack=%h dout=%b want sel=%0d", sel1, ack1, dout1, exp_sel);
          end
        end
        in_data = 16'($urandom);
      end
      n_cmp++;
      if (q.size() != 0) begin n_bad++; $display("FAIL wrap_timeout: %0d left want 0", q.size()); end
      req = 16'h8003;
      q.push_back(15); q.push_back(0); q.push_back(1);
      if (p == 1) q.delete();
    end
    req = 0;
  endtask

  task automatic test_stall();
    do_reset();
    ready = 0;
    req = 16'h0020;
    for (int c = 0; c < 10 && !valid1; c++) @(negedge clk);
    req = 0;
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (valid1 !== 1'b1 || sel1 !== 4'd5 || gnt1 !== 16'h0020 || ack1 !== 16'd0 || dout1 !== in_data[5]) begin
        n_bad++;
        $display("FAIL stall c=%0d: v=%b sel=%0d gnt=%h ack=%h dout=%b want 1/5/0020/0000/%b",
                 c, valid1, sel1, gnt1, ack1, dout1, in_data[5]);
      end
      in_data = in_data ^ 16'h0020;
      @(negedge clk);
    end
    ready = 1;
    q.push_back(5);
    #1;
    if (valid1 && ready) begin
      exp_sel = q.pop_front();
      n_cmp++;
      if (sel1 !== exp_sel || ack1 !== 16'h0020 || dout1 !== in_data[5]) begin
        n_bad++;
        $display("FAIL stall_release: sel=%0d ack=%h dout=%b want 5/0020/%b", sel1, ack1, dout1, in_data[5]);
      end
    end
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL stall_timeout: %0d left want 0", q.size()); end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (valid1 !== 1'b0) begin n_bad++; $display("FAIL stall_regrant: valid=%b want 0", valid1); end
  endtask

  task automatic test_burst();
    do_reset();
    req = 16'h0011;
    q.push_back(0); q.push_back(0); q.push_back(0); q.push_back(4); q.push_back(4); q.push_back(4); q.push_back(0);
    for (int p = 0; p < 3; p++) begin
      for (int c = 0; c < 40 && q.size() > 0; c++) begin
        @(negedge clk);
        if (valid3 && ready) begin
          exp_sel = q.pop_front();
          n_cmp++;
          if (sel3 !== exp_sel || ack3 !== (16'd1 << exp_sel) || dout3 !== in_data[exp_sel]) begin
            n_bad++;
            $display("FAIL burst p=%0d: sel=%0d ack=%h dout=%b want sel=%0d", p, sel3, ack3, dout3, exp_sel);
          end
        end
        in_data = 16'($urandom);
      end
      n_cmp++;
      if (q.size() != 0) begin n_bad++; $display("FAIL burst_timeout p=%0d: %0d left want 0", p, q.size()); end
      if (p == 0) begin
        do_reset();
        req = 16'h0011;
        q.push_back(0);
      end else begin
        req = 16'h0010;
        q.push_back(4);
      end
      if (p == 2) q.delete();
    end
    req = 0;
  endtask

  task automatic test_mask_reset();
    int seen;
    do_reset();
    mask = 16'hFFFE;
    req = 16'h0001;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (valid1) seen++;
    end
    n_cmp++;
    if (seen != 0) begin n_bad++; $display("FAIL masked: valid seen %0d times want 0", seen); end
    mask = 16'hFFFF;
    req = 16'h0008;
    for (int c = 0; c < 10 && !valid1; c++) @(negedge clk);
    rst_n = 0;
    #1;
    n_cmp++;
    if (valid1 !== 1'b0 || gnt1 !== 16'd0 || ack1 !== 16'd0 || sel1 !== 4'd0) begin
      n_bad++;
      $display("FAIL midreset: v=%b gnt=%h ack=%h sel=%0d want all 0", valid1, gnt1, ack1, sel1);
    end
    req = 16'h0006;
    @(negedge clk);
    rst_n = 1;
    q.push_back(1);
    for (int c = 0; c < 10 && q.size() > 0; c++) begin
      @(negedge clk);
      if (valid1 && ready) begin
        exp_sel = q.pop_front();
        n_cmp++;
        if (sel1 !== exp_sel || ack1 !== (16'd1 << exp_sel)) begin
          n_bad++;
          $display("FAIL postreset: sel=%0d ack=%h want sel=%0d", sel1, ack1, exp_sel);
        end
      end
    end
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL postreset_timeout: %0d left want 0", q.size()); end
    req = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_stall();
    test_burst();
    test_mask_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
